// File: rtl/ram_programmer.sv
// ram_programmer: loads the program RAM from a byte stream.
// Bytes arrive over a valid/ready handshake. Each byte is presented on
// addr/data_out, written with a registered active-low read_write strobe,
// and then the RAM is handed back to execution mode.
module ram_programmer #(
  parameter int WORDS         = 16,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [3:0] addr,
  output logic [7:0] data_out,
  output logic       read_write,
  output logic       run_prog,
  output logic       CE,
  output logic       busy,
  output logic       done,
  output logic [4:0] count
);

  // The phase counter only has to reach the longer of the two waits.
  localparam int MAXC = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [3:0]    LAST_ADDR   = 4'(WORDS - 1);
  localparam logic [4:0]    WORDS_W     = 5'(WORDS);

  typedef enum logic [2:0] {
    IDLE, WAIT_BYTE, SETUP, STROBE, HOLD, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] phase, phase_nxt;
  logic          byte_ready_nxt, read_write_nxt, run_prog_nxt, ce_nxt;
  logic          busy_nxt, done_nxt;
  logic [3:0]    addr_nxt;
  logic [7:0]    data_nxt;
  logic [4:0]    count_nxt;

  // State and every output are registered together; clr forces the idle values.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state      <= IDLE;
      phase      <= '0;
      byte_ready <= 1'b0;
      addr       <= 4'd0;
      data_out   <= 8'd0;
      read_write <= 1'b1;
      run_prog   <= 1'b1;
      CE         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= 5'd0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      byte_ready <= byte_ready_nxt;
      addr       <= addr_nxt;
      data_out   <= data_nxt;
      read_write <= read_write_nxt;
      run_prog   <= run_prog_nxt;
      CE         <= ce_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      count      <= count_nxt;
    end
  end

  // Next-state and next-output values; everything holds unless a state changes it.
  always_comb begin
    state_nxt      = state;
    phase_nxt      = phase;
    byte_ready_nxt = byte_ready;
    addr_nxt       = addr;
    data_nxt       = data_out;
    read_write_nxt = read_write;
    run_prog_nxt   = run_prog;
    ce_nxt         = CE;
    busy_nxt       = busy;
    done_nxt       = done;
    count_nxt      = count;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt      = WAIT_BYTE;
          run_prog_nxt   = 1'b0;
          ce_nxt         = 1'b0;
          busy_nxt       = 1'b1;
          addr_nxt       = 4'd0;
          count_nxt      = 5'd0;
          byte_ready_nxt = 1'b1;
        end
      end
      WAIT_BYTE: begin
        if (byte_valid) begin
          data_nxt       = byte_in;
          byte_ready_nxt = 1'b0;
          phase_nxt      = '0;
          state_nxt      = SETUP;
        end else if (abort) begin
          state_nxt      = IDLE;
          run_prog_nxt   = 1'b1;
          ce_nxt         = 1'b1;
          busy_nxt       = 1'b0;
          byte_ready_nxt = 1'b0;
        end
      end
      SETUP: begin
        if (phase == SETUP_LAST) begin
          read_write_nxt = 1'b0;
          phase_nxt      = '0;
          state_nxt      = STROBE;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      STROBE: begin
        if (phase == STROBE_LAST) begin
          read_write_nxt = 1'b1;
          phase_nxt      = '0;
          state_nxt      = HOLD;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      HOLD: begin
        if (count < WORDS_W) count_nxt = count + 5'd1;
        if (addr == LAST_ADDR) begin
          state_nxt    = DONE;
          done_nxt     = 1'b1;
          run_prog_nxt = 1'b1;
          ce_nxt       = 1'b1;
          busy_nxt     = 1'b0;
          addr_nxt     = 4'd0;
        end else begin
          addr_nxt       = addr + 4'd1;
          byte_ready_nxt = 1'b1;
          state_nxt      = WAIT_BYTE;
        end
      end
      DONE: begin
        done_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_programmer.sv
// Testbench for ram_programmer: two instances (default timing with 16 words,
// and 4 words with 3 setup / 2 strobe cycles) driven by directed stimulus.
// Expected writes go into a queue at each handshake; a monitor pops one at
// every falling read_write and checks addr/data, strobe width and stability.
module tb_ram_programmer;

  logic       clk = 1'b0;
  logic       clr_a, start_a, abort_a, byte_valid_a;
  logic [7:0] byte_in_a;
  logic       byte_ready_a, read_write_a, run_prog_a, ce_a, busy_a, done_a;
  logic [3:0] addr_a;
  logic [7:0] data_out_a;
  logic [4:0] count_a;

  logic       clr_b, start_b, abort_b, byte_valid_b;
  logic [7:0] byte_in_b;
  logic       byte_ready_b, read_write_b, run_prog_b, ce_b, busy_b, done_b;
  logic [3:0] addr_b;
  logic [7:0] data_out_b;
  logic [4:0] count_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int idx_a = 0;
  int idx_b = 0;
  int start_cyc = 0;

  logic [7:0]  bytes [16];
  logic [11:0] q_a [$];
  logic [11:0] q_b [$];
  int          fall_cyc_a [$];
  int          fall_cyc_b [$];

  bit         prev_rw [2]    = '{1'b1, 1'b1};
  bit         skip_len [2]   = '{1'b0, 1'b0};
  int         low_len [2]    = '{0, 0};
  int         falls [2]      = '{0, 0};
  int         done_seen [2]  = '{0, 0};
  int         done_cyc [2]   = '{0, 0};
  int         strobe_len [2] = '{1, 2};
  logic [3:0] cur_addr [2];
  logic [7:0] cur_data [2];

  ram_programmer #(.WORDS(16), .SETUP_CYCLES(1), .STROBE_CYCLES(1)) dut_a (
    .clk(clk), .clr(clr_a), .start(start_a), .abort(abort_a),
    .byte_in(byte_in_a), .byte_valid(byte_valid_a), .byte_ready(byte_ready_a),
    .addr(addr_a), .data_out(data_out_a), .read_write(read_write_a),
    .run_prog(run_prog_a), .CE(ce_a), .busy(busy_a), .done(done_a), .count(count_a)
  );

  ram_programmer #(.WORDS(4), .SETUP_CYCLES(3), .STROBE_CYCLES(2)) dut_b (
    .clk(clk), .clr(clr_b), .start(start_b), .abort(abort_b),
    .byte_in(byte_in_b), .byte_valid(byte_valid_b), .byte_ready(byte_ready_b),
    .addr(addr_b), .data_out(data_out_b), .read_write(read_write_b),
    .run_prog(run_prog_b), .CE(ce_b), .busy(busy_b), .done(done_b), .count(count_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One negedge step: drive inputs, and record the write the upcoming edge accepts.
  task automatic applyStimulus(input int s, input logic v, input logic st, input logic ab);
    @(negedge clk);
    if (s == 0) begin
      start_a = st; abort_a = ab; byte_valid_a = v; byte_in_a = bytes[idx_a % 16];
      if (v && byte_ready_a && clr_a) begin
        q_a.push_back({4'(idx_a), bytes[idx_a % 16]});
        idx_a++;
      end
    end else begin
      start_b = st; abort_b = ab; byte_valid_b = v; byte_in_b = bytes[idx_b % 16];
      if (v && byte_ready_b && clr_b) begin
        q_b.push_back({4'(idx_b), bytes[idx_b % 16]});
        idx_b++;
      end
    end
  endtask

  task automatic startSession(input int s);
    falls[s] = 0;
    done_seen[s] = 0;
    if (s == 0) begin idx_a = 0; fall_cyc_a.delete(); end
    else begin idx_b = 0; fall_cyc_b.delete(); end
    applyStimulus(s, 1'b0, 1'b1, 1'b0);
    start_cyc = cyc + 1;
  endtask

  task automatic monitorStep(input int s);
    logic       rw, dn, got;
    logic [3:0] ad;
    logic [7:0] dt;
    logic [11:0] e;
    rw = (s == 0) ? read_write_a : read_write_b;
    dn = (s == 0) ? done_a : done_b;
    ad = (s == 0) ? addr_a : addr_b;
    dt = (s == 0) ? data_out_a : data_out_b;
    got = 1'b0;
    e = '0;
    if (dn) begin
      if (done_seen[s] == 0) done_cyc[s] = cyc;
      done_seen[s]++;
    end
    if (prev_rw[s] && !rw) begin
      falls[s]++;
      low_len[s] = 1;
      if (s == 0) begin
        fall_cyc_a.push_back(cyc);
        if (q_a.size() > 0) begin e = q_a.pop_front(); got = 1'b1; end
      end else begin
        fall_cyc_b.push_back(cyc);
        if (q_b.size() > 0) begin e = q_b.pop_front(); got = 1'b1; end
      end
      checkOutput("strobe_has_expected_write", 32'(got), 32'd1);
      cur_addr[s] = e[11:8];
      cur_data[s] = e[7:0];
      checkOutput("write_addr", 32'(ad), 32'(cur_addr[s]));
      checkOutput("write_data", 32'(dt), 32'(cur_data[s]));
    end else if (!prev_rw[s] && !rw) begin
      low_len[s]++;
      checkOutput("addr_stable_in_strobe", 32'(ad), 32'(cur_addr[s]));
      checkOutput("data_stable_in_strobe", 32'(dt), 32'(cur_data[s]));
    end else if (!prev_rw[s] && rw && !skip_len[s]) begin
      checkOutput("strobe_width", 32'(low_len[s]), 32'(strobe_len[s]));
      checkOutput("addr_hold_after_rise", 32'(ad), 32'(cur_addr[s]));
      checkOutput("data_hold_after_rise", 32'(dt), 32'(cur_data[s]));
    end
    prev_rw[s] = rw;
  endtask

  // Monitor both instances on every falling clock edge.
  always @(negedge clk) begin
    monitorStep(0);
    monitorStep(1);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int k = 0; k < 16; k++) bytes[k] = 8'h10 + 8'(k) * 8'h11;
    clr_a = 1'b0; start_a = 1'b0; abort_a = 1'b0; byte_valid_a = 1'b0; byte_in_a = 8'h00;
    clr_b = 1'b0; start_b = 1'b0; abort_b = 1'b0; byte_valid_b = 1'b0; byte_in_b = 8'h00;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_addr", 32'(addr_a), 32'd0);
    checkOutput("rst_data", 32'(data_out_a), 32'd0);
    checkOutput("rst_read_write", 32'(read_write_a), 32'd1);
    checkOutput("rst_run_prog", 32'(run_prog_a), 32'd1);
    checkOutput("rst_ce", 32'(ce_a), 32'd1);
    checkOutput("rst_byte_ready", 32'(byte_ready_a), 32'd0);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_done", 32'(done_a), 32'd0);
    checkOutput("rst_count", 32'(count_a), 32'd0);
    checkOutput("rst_b_read_write", 32'(read_write_b), 32'd1);
    clr_a = 1'b1;
    clr_b = 1'b1;

    $display("[TB] idle without start");
    falls[0] = 0;
    repeat (20) applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_no_strobe", 32'(falls[0]), 32'd0);
    checkOutput("idle_busy", 32'(busy_a), 32'd0);
    checkOutput("idle_run_prog", 32'(run_prog_a), 32'd1);
    checkOutput("idle_byte_ready", 32'(byte_ready_a), 32'd0);

    $display("[TB] full 16-word load, byte_valid held high");
    startSession(0);
    for (int i = 0; i < 150 && done_seen[0] == 0; i++) applyStimulus(0, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("full_strobes", 32'(falls[0]), 32'd16);
    checkOutput("full_done_seen", 32'(done_seen[0]), 32'd1);
    checkOutput("full_done_edge", 32'(done_cyc[0] - start_cyc), 32'd64);
    checkOutput("full_count", 32'(count_a), 32'd16);
    checkOutput("full_run_prog", 32'(run_prog_a), 32'd1);
    checkOutput("full_ce", 32'(ce_a), 32'd1);
    checkOutput("full_busy", 32'(busy_a), 32'd0);
    checkOutput("full_addr", 32'(addr_a), 32'd0);
    checkOutput("full_queue_empty", 32'(q_a.size()), 32'd0);

    $display("[TB] abort after three words");
    startSession(0);
    for (int i = 0; i < 60 && idx_a < 3; i++) applyStimulus(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20 && read_write_a; i++) applyStimulus(0, 1'b0, 1'b0, 1'b0);
    abort_a = 1'b1;
    checkOutput("abort_in_strobe", 32'(read_write_a), 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_ignored_hold_busy", 32'(busy_a), 32'd1);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_wait_busy", 32'(busy_a), 32'd1);
    checkOutput("abort_wait_count", 32'(count_a), 32'd3);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_busy", 32'(busy_a), 32'd0);
    checkOutput("abort_done", 32'(done_seen[0]), 32'd0);
    checkOutput("abort_count", 32'(count_a), 32'd3);
    checkOutput("abort_run_prog", 32'(run_prog_a), 32'd1);
    checkOutput("abort_ce", 32'(ce_a), 32'd1);
    checkOutput("abort_strobes", 32'(falls[0]), 32'd3);
    checkOutput("abort_queue_empty", 32'(q_a.size()), 32'd0);

    $display("[TB] setup 3 / strobe 2 timing, four words");
    startSession(1);
    for (int i = 0; i < 100 && done_seen[1] == 0; i++) applyStimulus(1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    checkOutput("slow_strobes", 32'(falls[1]), 32'd4);
    for (int i = 0; i + 1 < fall_cyc_b.size(); i++)
      checkOutput("slow_period", 32'(fall_cyc_b[i+1] - fall_cyc_b[i]), 32'd7);
    checkOutput("slow_done_edge", 32'(done_cyc[1] - start_cyc), 32'd28);
    checkOutput("slow_count", 32'(count_b), 32'd4);

    $display("[TB] throttled byte_valid, one in five cycles");
    startSession(1);
    for (int i = 0; i < 300 && done_seen[1] == 0; i++) applyStimulus(1, (cyc % 5) == 0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    checkOutput("thr_strobes", 32'(falls[1]), 32'd4);
    for (int i = 0; i + 1 < fall_cyc_b.size(); i++)
      checkOutput("thr_spacing", 32'(fall_cyc_b[i+1] - fall_cyc_b[i]), 32'd10);
    checkOutput("thr_done_seen", 32'(done_seen[1]), 32'd1);
    checkOutput("thr_count", 32'(count_b), 32'd4);
    checkOutput("thr_queue_empty", 32'(q_b.size()), 32'd0);

    $display("[TB] clr asserted while read_write is low");
    startSession(1);
    for (int i = 0; i < 40 && read_write_b; i++) applyStimulus(1, 1'b1, 1'b0, 1'b0);
    checkOutput("clr_at_strobe", 32'(read_write_b), 32'd0);
    clr_b = 1'b0;
    byte_valid_b = 1'b0;
    skip_len[1] = 1'b1;
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    checkOutput("clr_read_write", 32'(read_write_b), 32'd1);
    checkOutput("clr_run_prog", 32'(run_prog_b), 32'd1);
    checkOutput("clr_ce", 32'(ce_b), 32'd1);
    checkOutput("clr_addr", 32'(addr_b), 32'd0);
    checkOutput("clr_busy", 32'(busy_b), 32'd0);
    checkOutput("clr_byte_ready", 32'(byte_ready_b), 32'd0);
    checkOutput("clr_count", 32'(count_b), 32'd0);
    clr_b = 1'b1;
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    skip_len[1] = 1'b0;
    q_b.delete();

    $display("[TB] clean session after clr");
    startSession(1);
    for (int i = 0; i < 100 && done_seen[1] == 0; i++) applyStimulus(1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    checkOutput("post_clr_strobes", 32'(falls[1]), 32'd4);
    checkOutput("post_clr_done", 32'(done_seen[1]), 32'd1);
    checkOutput("post_clr_count", 32'(count_b), 32'd4);
    checkOutput("post_clr_run_prog", 32'(run_prog_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
